// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, maps ALUOp/funct to
// the ALU select and B-invert, and forwards EX/MEM and MEM/WB results onto the EX operands.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RW-1:0]    id_rs,
  input  logic [RW-1:0]    id_rt,
  input  logic [RW-1:0]    id_rd,
  input  logic [1:0]       id_alu_op,
  input  logic [5:0]       id_funct,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             exmem_reg_write,
  input  logic [RW-1:0]    exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RW-1:0]    memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [2:0]       ex_alu_sel,
  output logic             ex_invert,
  output logic [RW-1:0]    ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             ex_decode_err
);

  // Packed as {err, invert, sel}; unsupported encodings fall back to add.
  function automatic logic [4:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
    logic [4:0] d;
    d = 5'b10_010;
    case (op)
      2'b00: d = 5'b00_010;
      2'b01: d = 5'b01_110;
      2'b10: begin
        case (funct)
          6'b100000: d = 5'b00_010;
          6'b100010: d = 5'b01_110;
          6'b100100: d = 5'b00_000;
          6'b100101: d = 5'b00_001;
          6'b101010: d = 5'b01_111;
          default:   d = 5'b10_010;
        endcase
      end
      default: d = 5'b10_010;
    endcase
    return d;
  endfunction

  // Register 0 is hardwired, so a write to it is never a forwarding source.
  function automatic logic [WIDTH-1:0] fwd(
    input logic [RW-1:0]    src,
    input logic [WIDTH-1:0] q,
    input logic             em_we,
    input logic [RW-1:0]    em_rd,
    input logic [WIDTH-1:0] em_res,
    input logic             mw_we,
    input logic [RW-1:0]    mw_rd,
    input logic [WIDTH-1:0] mw_res
  );
    if (em_we && (em_rd != '0) && (em_rd == src))      return em_res;
    else if (mw_we && (mw_rd != '0) && (mw_rd == src)) return mw_res;
    else                                               return q;
  endfunction

  logic             vld_p1;
  logic             alu_src_p1, reg_write_p1, mem_read_p1, mem_write_p1, mem_to_reg_p1;
  logic [2:0]       alu_sel_p1;
  logic             invert_p1, decode_err_p1;
  logic [WIDTH-1:0] rs_data_p1, rt_data_p1, imm_p1;
  logic [RW-1:0]    rs_p1, rt_p1, rd_p1;
  logic [4:0]       dec_p0;
  logic [WIDTH-1:0] rs_fwd_p1, rt_fwd_p1;

  // ---- ID -> EX boundary
  always_comb dec_p0 = alu_decode(id_alu_op, id_funct);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      alu_src_p1    <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      alu_sel_p1    <= 3'b010;
      invert_p1     <= 1'b0;
      decode_err_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1        <= 1'b0;
      alu_src_p1    <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      alu_sel_p1    <= 3'b010;
      invert_p1     <= 1'b0;
      decode_err_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1        <= id_valid;
      alu_src_p1    <= id_valid & id_alu_src;
      reg_write_p1  <= id_valid & id_reg_write;
      mem_read_p1   <= id_valid & id_mem_read;
      mem_write_p1  <= id_valid & id_mem_write;
      mem_to_reg_p1 <= id_valid & id_mem_to_reg;
      alu_sel_p1    <= id_valid ? dec_p0[2:0] : 3'b010;
      invert_p1     <= id_valid & dec_p0[3];
      decode_err_p1 <= id_valid & dec_p0[4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      rd_p1      <= '0;
    end else if (!flush && !stall) begin
      rs_data_p1 <= id_rs_data;
      rt_data_p1 <= id_rt_data;
      imm_p1     <= id_imm;
      rs_p1      <= id_rs;
      rt_p1      <= id_rt;
      rd_p1      <= id_rd;
    end
  end

  // ---- EX operand forwarding
  always_comb begin
    rs_fwd_p1 = fwd(rs_p1, rs_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                    memwb_reg_write, memwb_rd, memwb_result);
    rt_fwd_p1 = fwd(rt_p1, rt_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                    memwb_reg_write, memwb_rd, memwb_result);
  end

  assign ex_valid      = vld_p1;
  assign ex_a          = rs_fwd_p1;
  assign ex_b          = alu_src_p1 ? imm_p1 : rt_fwd_p1;
  assign ex_store_data = rt_fwd_p1;
  assign ex_alu_sel    = alu_sel_p1;
  assign ex_invert     = invert_p1;
  assign ex_rd         = rd_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_mem_write  = mem_write_p1;
  assign ex_mem_to_reg = mem_to_reg_p1;
  assign ex_decode_err = decode_err_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, decode, forwarding, stall/flush, back-to-back.
module tb_id_ex_stage;
  localparam int WIDTH = 32;
  localparam int RW    = 5;

  logic             clk = 1'b0;
  logic             rst_n, stall, flush, id_valid;
  logic [WIDTH-1:0] id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0]    id_rs, id_rt, id_rd;
  logic [1:0]       id_alu_op;
  logic [5:0]       id_funct;
  logic             id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic             exmem_reg_write, memwb_reg_write;
  logic [RW-1:0]    exmem_rd, memwb_rd;
  logic [WIDTH-1:0] exmem_result, memwb_result;
  logic             ex_valid, ex_invert, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic             ex_decode_err;
  logic [WIDTH-1:0] ex_a, ex_b, ex_store_data;
  logic [2:0]       ex_alu_sel;
  logic [RW-1:0]    ex_rd;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage #(.WIDTH(WIDTH), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_alu_sel(ex_alu_sel), .ex_invert(ex_invert), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_decode_err(ex_decode_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic v, input logic rw, input logic mr,
                         input logic mw, input logic [2:0] sel, input logic inv, input logic err);
    chk({tag, "_valid"}, 32'(ex_valid), 32'(v));
    chk({tag, "_rw"},    32'(ex_reg_write), 32'(rw));
    chk({tag, "_mr"},    32'(ex_mem_read), 32'(mr));
    chk({tag, "_mw"},    32'(ex_mem_write), 32'(mw));
    chk({tag, "_sel"},   32'(ex_alu_sel), 32'(sel));
    chk({tag, "_inv"},   32'(ex_invert), 32'(inv));
    chk({tag, "_err"},   32'(ex_decode_err), 32'(err));
  endtask

  logic [5:0] functs [6];
  logic [2:0] sels   [6];
  logic       invs   [6];
  logic       errs   [6];

  initial begin
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    sels   = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
    invs   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    errs   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_alu_op = 2'b00; id_funct = '0;
    id_alu_src = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    id_mem_to_reg = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;

    // Reset state
    step(); step();
    chk_ctl("rst", 0, 0, 0, 0, 3'b010, 0, 0);
    chk("rst_a", ex_a, 32'h0);
    chk("rst_rd", 32'(ex_rd), 32'h0);
    chk("rst_m2r", 32'(ex_mem_to_reg), 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Invalid loads keep the stage empty
    id_reg_write = 1'b1; id_mem_read = 1'b1;
    step();
    chk_ctl("inv", 0, 0, 0, 0, 3'b010, 0, 0);
    id_reg_write = 1'b0; id_mem_read = 1'b0;

    // Valid load then asynchronous reset between edges
    id_valid = 1'b1; id_rs = 5'd3; id_rt = 5'd4; id_rd = 5'd5;
    id_rs_data = 32'h11; id_rt_data = 32'h22; id_alu_op = 2'b01; id_reg_write = 1'b1;
    step();
    chk_ctl("ld", 1, 1, 0, 0, 3'b110, 1, 0);
    chk("ld_a", ex_a, 32'h11);
    chk("ld_b", ex_b, 32'h22);
    chk("ld_rd", 32'(ex_rd), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("arst", 0, 0, 0, 0, 3'b010, 0, 0);
    chk("arst_a", ex_a, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // Decode sweep
    id_alu_op = 2'b10;
    for (int i = 0; i < 6; i++) begin
      id_funct = functs[i];
      step();
      chk($sformatf("dec%0d_sel", i), 32'(ex_alu_sel), 32'(sels[i]));
      chk($sformatf("dec%0d_inv", i), 32'(ex_invert), 32'(invs[i]));
      chk($sformatf("dec%0d_err", i), 32'(ex_decode_err), 32'(errs[i]));
    end
    id_alu_op = 2'b11; id_funct = 6'h20;
    step();
    chk("op11_err", 32'(ex_decode_err), 32'd1);
    chk("op11_sel", 32'(ex_alu_sel), 32'(3'b010));
    id_alu_op = 2'b00;
    step();
    chk("op00_err", 32'(ex_decode_err), 32'd0);

    // Flush clears a pending decode error
    id_alu_op = 2'b11; flush = 1'b1;
    step();
    chk("flerr", 32'(ex_decode_err), 32'd0);
    flush = 1'b0; id_alu_op = 2'b00;

    // Forwarding priority and register-0 exclusion
    id_rs = 5'd3; id_rt = 5'd4; id_rs_data = 32'h1234; id_rt_data = 32'h4444;
    step();
    exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'hAAAA0000;
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h5555;
    #1 chk("fw_both", ex_a, 32'hAAAA0000);
    chk("fw_b_none", ex_b, 32'h4444);
    exmem_reg_write = 1'b0;
    #1 chk("fw_mw", ex_a, 32'h5555);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1 chk("fw_r0", ex_a, 32'h1234);
    memwb_rd = 5'd4;
    #1 chk("fw_rt_mw", ex_b, 32'h5555);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

    // Immediate path with forwarded store data
    id_alu_src = 1'b1; id_imm = 32'hFFFFFFFC;
    step();
    exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hBEEF0000;
    #1 chk("imm_b", ex_b, 32'hFFFFFFFC);
    chk("imm_sd", ex_store_data, 32'hBEEF0000);
    chk("imm_a", ex_a, 32'h1234);
    exmem_reg_write = 1'b0; id_alu_src = 1'b0;

    // Stall holds A while B is presented, then stall+flush inserts a bubble
    id_rd = 5'd7; id_rs = 5'd1; id_rs_data = 32'hA; id_reg_write = 1'b1; id_mem_read = 1'b1;
    step();
    id_rd = 5'd9; id_rs_data = 32'hB; id_reg_write = 1'b0; id_mem_read = 1'b0;
    id_mem_write = 1'b1; id_alu_op = 2'b01; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ctl($sformatf("stl%0d", i), 1, 1, 1, 0, 3'b010, 0, 0);
      chk($sformatf("stl%0d_rd", i), 32'(ex_rd), 32'd7);
      chk($sformatf("stl%0d_a", i), ex_a, 32'hA);
    end
    memwb_reg_write = 1'b1; memwb_rd = 5'd1; memwb_result = 32'hC0FFEE;
    #1 chk("stl_track", ex_a, 32'hC0FFEE);
    memwb_reg_write = 1'b0;
    flush = 1'b1;
    step();
    chk_ctl("sfl", 0, 0, 0, 0, 3'b010, 0, 0);
    stall = 1'b0; flush = 1'b0;
    step();
    chk_ctl("ldB", 1, 0, 0, 1, 3'b110, 1, 0);
    chk("ldB_rd", 32'(ex_rd), 32'd9);
    chk("ldB_a", ex_a, 32'hB);

    // Reset during a stall clears immediately; first edge after release loads
    stall = 1'b1; id_rd = 5'd2;
    #2 rst_n = 1'b0;
    #1 chk_ctl("rstl", 0, 0, 0, 0, 3'b010, 0, 0);
    @(negedge clk); rst_n = 1'b1; stall = 1'b0;
    step();
    chk("rstl_ld_rd", 32'(ex_rd), 32'd2);
    chk("rstl_ld_v", 32'(ex_valid), 32'd1);

    // Back-to-back valid instructions
    id_mem_write = 1'b0; id_alu_op = 2'b00; id_reg_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      id_rd = 5'(10 + i); id_rs_data = 32'h100 + 32'(i);
      step();
      chk($sformatf("b2b%0d_rd", i), 32'(ex_rd), 32'(10 + i));
      chk($sformatf("b2b%0d_a", i), ex_a, 32'h100 + 32'(i));
      chk($sformatf("b2b%0d_v", i), 32'(ex_valid), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
